// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types for the MEM->WB boundary.
// Default beat layout and the hard-wired zero register index.
package cpu_pipe_pkg;

  localparam int unsigned WB_DATA_W = 64;
  localparam int unsigned WB_RD_W   = 5;

  localparam logic [4:0] ZERO_REG_IDX = 5'd31;

  typedef struct packed {
    logic                 regwrite;
    logic [WB_RD_W-1:0]   rd;
    logic [WB_DATA_W-1:0] data;
  } wb_beat_t;

endpackage

// File: rtl/pipe_beat_reg.sv
// W-bit beat register with load enable.
// Ports: clk, rst_n (async low), en_i, d_i, q_o.
module pipe_beat_reg #(
  parameter int unsigned W = 70
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/wb_pipe_stage.sv
// MEM->WB stage register: valid/ready, flush, skid, XZR squash.
// Ports: in_* upstream beat, out_* to regfile/forwarding, stall_cnt.
module wb_pipe_stage
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned RD_W      = 5,
  parameter int unsigned SKID      = 1,
  parameter int unsigned ZR_SQUASH = 1,
  parameter int unsigned ZERO_REG  = 32'(ZERO_REG_IDX),
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_regwrite,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_regwrite,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              regwrite;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } beat_t;

  localparam int unsigned W = $bits(beat_t);
  localparam logic [RD_W-1:0] ZR = RD_W'(ZERO_REG);

  beat_t in_beat, main_d, main_q, skid_q;
  logic  valid_q, valid_d;
  logic  skid_v_q, skid_v_d;
  logic  main_ld, skid_ld;
  logic  acc, iss, zr_hit;
  logic  [CNT_W-1:0] stall_q;

  assign zr_hit = (ZR_SQUASH != 0) && (in_rd == ZR);

  always_comb begin
    in_beat          = '0;
    in_beat.regwrite = in_regwrite & !zr_hit;
    in_beat.rd       = in_rd;
    in_beat.data     = in_data;
  end

  assign acc = in_valid & in_ready;
  assign iss = valid_q & out_ready;

  // Main reg refills when empty or issuing; the skid entry
  // (if occupied) drains first, which is what keeps FIFO order.
  always_comb begin
    valid_d  = valid_q;
    skid_v_d = skid_v_q;
    main_d   = in_beat;
    main_ld  = 1'b0;
    skid_ld  = 1'b0;
    if (flush) begin
      valid_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (iss || !valid_q) begin
      main_ld = acc | skid_v_q;
      if (skid_v_q) begin
        main_d   = skid_q;
        valid_d  = 1'b1;
        skid_v_d = 1'b0;
      end else begin
        valid_d = acc;
      end
    end else if (acc) begin
      skid_ld  = 1'b1;
      skid_v_d = 1'b1;
    end
  end

  pipe_beat_reg #(.W(W)) u_main (
    .clk   (clk),
    .rst_n (reset),
    .en_i  (main_ld),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  if (SKID != 0) begin : g_skid
    pipe_beat_reg #(.W(W)) u_skid (
      .clk   (clk),
      .rst_n (reset),
      .en_i  (skid_ld),
      .d_i   (in_beat),
      .q_o   (skid_q)
    );

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        skid_v_q <= 1'b0;
      end else begin
        skid_v_q <= skid_v_d;
      end
    end

    // Registered: no comb path from out_ready.
    assign in_ready = !skid_v_q;
  end else begin : g_noskid
    assign skid_q   = '0;
    assign skid_v_q = 1'b0;
    assign in_ready = out_ready | !valid_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (cnt_clr) begin
      stall_q <= '0;
    end else if (valid_q && !out_ready && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign out_valid    = valid_q;
  assign out_regwrite = main_q.regwrite & valid_q;
  assign out_rd       = main_q.rd;
  assign out_data     = main_q.data;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Bench for wb_pipe_stage: queue model, directed + random.
// Second instance (SKID=0, ZR_SQUASH=0) checked in stream phases.
module tb_wb_pipe_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_regwrite = 1'b0;
  logic [4:0]  in_rd = '0;
  logic [63:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        cnt_clr = 1'b0;

  logic        in_ready, out_valid, out_regwrite;
  logic [4:0]  out_rd;
  logic [63:0] out_data;
  logic [3:0]  stall_cnt;

  logic        in_ready0, out_valid0, out_regwrite0;
  logic [4:0]  out_rd0;
  logic [63:0] out_data0;
  logic [15:0] stall_cnt0;

  always #5 clk = ~clk;

  wb_pipe_stage #(.CNT_W(4)) dut (
    .clk(clk), .reset(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_regwrite(in_regwrite), .in_rd(in_rd),
    .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_regwrite(out_regwrite),
    .out_rd(out_rd), .out_data(out_data),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
  );

  wb_pipe_stage #(.SKID(0), .ZR_SQUASH(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_regwrite(in_regwrite), .in_rd(in_rd),
    .in_data(in_data), .out_valid(out_valid0),
    .out_ready(out_ready), .out_regwrite(out_regwrite0),
    .out_rd(out_rd0), .out_data(out_data0),
    .cnt_clr(cnt_clr), .stall_cnt(stall_cnt0)
  );

  typedef struct {
    bit        rw;
    bit [4:0]  rd;
    bit [63:0] d;
  } mbeat_t;

  mbeat_t mq[$];
  int     mcnt = 0;
  int     checks = 0;
  int     passes = 0;
  bit     cmp0 = 1'b0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h",
                tag, obs, exp);
  endtask

  task automatic check_all();
    bit h;
    h = mq.size() > 0;
    chk("in_ready", in_ready, mq.size() < 2);
    chk("out_valid", out_valid, h);
    chk("out_regwrite", out_regwrite,
        h ? (mq[0].rw && mq[0].rd != 5'd31) : 1'b0);
    if (h) begin
      chk("out_rd", out_rd, mq[0].rd);
      chk("out_data", out_data, mq[0].d);
    end
    chk("stall_cnt", stall_cnt, mcnt);
    if (cmp0) begin
      chk("d0_in_ready", in_ready0, 1'b1);
      chk("d0_out_valid", out_valid0, h);
      chk("d0_regwrite", out_regwrite0,
          h ? mq[0].rw : 1'b0);
      if (h) begin
        chk("d0_out_rd", out_rd0, mq[0].rd);
        chk("d0_out_data", out_data0, mq[0].d);
      end
      chk("d0_stall_cnt", stall_cnt0, 0);
    end
  endtask

  task automatic step(input bit v, input bit rw,
                      input bit [4:0] rd,
                      input bit [63:0] d,
                      input bit ordy, input bit fl,
                      input bit clr);
    bit acc, iss;
    mbeat_t b;
    in_valid    = v;
    in_regwrite = rw;
    in_rd       = rd;
    in_data     = d;
    out_ready   = ordy;
    flush       = fl;
    cnt_clr     = clr;
    acc = v && (mq.size() < 2);
    iss = (mq.size() > 0) && ordy;
    if (clr) mcnt = 0;
    else if (mq.size() > 0 && !ordy && mcnt < 15) mcnt++;
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (iss) void'(mq.pop_front());
      if (acc) begin
        b.rw = rw; b.rd = rd; b.d = d;
        mq.push_back(b);
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 1'b0, 5'd0, 64'd0, ordy, 1'b0, 1'b0);
  endtask

  task automatic zero_outs(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_rw"}, out_regwrite, 1'b0);
    chk({tag, "_rd"}, out_rd, 5'd0);
    chk({tag, "_data"}, out_data, 64'd0);
    chk({tag, "_cnt"}, stall_cnt, 4'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    zero_outs("rst");
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // Streaming, both instances must agree.
    cmp0 = 1'b1;
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, 5'(3 + i), 64'h1000 + 64'(i),
           1'b1, 1'b0, 1'b0);
    idle(1'b1);
    // Zero-register squash.
    step(1'b1, 1'b1, 5'd31, 64'hDEAD, 1'b1, 1'b0, 1'b0);
    chk("zr_rw", out_regwrite, 1'b0);
    chk("zr_rd", out_rd, 5'd31);
    chk("zr_rw0", out_regwrite0, 1'b1);
    idle(1'b1);
    cmp0 = 1'b0;

    // Back-pressure: rd1 main, rd2 skid, rd3 held.
    step(1'b1, 1'b1, 5'd1, 64'h11, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 5'd2, 64'h22, 1'b0, 1'b0, 1'b0);
    chk("bp_in_ready", in_ready, 1'b0);
    repeat (4)
      step(1'b1, 1'b1, 5'd3, 64'h33, 1'b0, 1'b0, 1'b0);
    chk("bp_stall5", stall_cnt, 4'd5);
    step(1'b1, 1'b1, 5'd3, 64'h33, 1'b1, 1'b0, 1'b0);
    chk("bp_rd2", out_rd, 5'd2);
    step(1'b1, 1'b1, 5'd3, 64'h33, 1'b1, 1'b0, 1'b0);
    chk("bp_rd3", out_rd, 5'd3);
    idle(1'b1);

    // Flush with both entries full and a beat incoming.
    step(1'b1, 1'b1, 5'd4, 64'h44, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd5, 64'h55, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd9, 64'h99, 1'b0, 1'b1, 1'b0);
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_in_ready", in_ready, 1'b1);
    repeat (2) idle(1'b1);

    // Saturation at 15 and clear priority.
    step(1'b1, 1'b0, 5'd6, 64'h66, 1'b0, 1'b0, 1'b1);
    repeat (20) idle(1'b0);
    chk("sat15", stall_cnt, 4'd15);
    step(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    chk("clr0", stall_cnt, 4'd0);
    idle(1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 99) < 70),
           1'($urandom),
           5'($urandom_range(0, 31)),
           {$urandom, $urandom},
           1'($urandom_range(0, 99) < 60),
           1'($urandom_range(0, 99) < 4),
           1'($urandom_range(0, 99) < 4));

    // Reset in the middle of a stall.
    step(1'b1, 1'b1, 5'd7, 64'h77, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 5'd8, 64'h88, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5'd9, 64'h99, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    mq.delete();
    mcnt = 0;
    zero_outs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_ready", in_ready, 1'b1);
    @(negedge clk);
    idle(1'b1);
    idle(1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
